// File: rtl/best_d_core_pkg.sv
// best_d_core_pkg: shared widths and constants for the best_d split-parameter pipeline
package best_d_core_pkg;
  localparam int N_W = 12;
  localparam int T_W = 5;
  localparam int D_W = 11;
  localparam int U_W = 4;
  localparam int M_W = 14;
  localparam int P_W = 30;
  localparam logic [15:0] LN2_Q16 = 16'd45426;
  localparam logic [U_W-1:0] U_MIN = 4'd1;
  localparam logic [U_W-1:0] U_MAX = 4'd10;
endpackage

// File: rtl/best_d_core_pow2_floor_cmp.sv
// pow2_floor_cmp: largest k in 2..10 with p >= t<<(k+17), else U_MIN
module pow2_floor_cmp
  import best_d_core_pkg::*;
(
  input  logic [P_W-1:0] p,
  input  logic [T_W-1:0] t,
  output logic [U_W-1:0] u
);
  logic [8:0] hit;
  for (genvar k = 0; k < 9; k++) begin : g_cmp
    assign hit[k] = {2'b0, p} >= ({27'b0, t} << (k + 19));
  end
  always_comb begin
    u = U_MIN;
    for (int i = 0; i < 9; i++) u = hit[i] ? U_W'(i + 2) : u;
  end
endmodule

// File: rtl/best_d_core.sv
// best_d_core: two-stage pipeline computing power-of-two split parameter d = 2^u from (n, t)
module best_d_core
  import best_d_core_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [N_W-1:0] n,
  input  logic [T_W-1:0] t,
  output logic [D_W-1:0] d,
  output logic [U_W-1:0] u_minus_1
);
  logic signed [M_W-1:0] m;
  logic [P_W-1:0] p_d, p_q;
  logic [T_W-1:0] t_q;
  logic [U_W-1:0] cmp_u, u;
  logic [D_W-1:0] d_d, d_q;
  logic [U_W-1:0] u_minus_1_d, u_minus_1_q;
  always_comb begin
    m = $signed({1'b0, n, 1'b0}) - $signed({9'b0, t}) + 14'sd1;
    p_d = m > 14'sd0 ? {16'b0, m} * {14'b0, LN2_Q16} : '0;
  end
  pow2_floor_cmp u_cmp (.p(p_q), .t(t_q), .u(cmp_u));
  always_comb begin
    u = t_q == '0 ? U_MAX : cmp_u;
    d_d = {{(D_W-1){1'b0}}, 1'b1} << u;
    u_minus_1_d = u - U_MIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
      t_q <= '0;
      d_q <= '0;
      u_minus_1_q <= '0;
    end else begin
      p_q <= p_d;
      t_q <= t;
      d_q <= d_d;
      u_minus_1_q <= u_minus_1_d;
    end
  end
  assign d = d_q;
  assign u_minus_1 = u_minus_1_q;
endmodule

// File: tb/tb_best_d_core.sv
// tb_best_d_core: directed and random checks of best_d_core against an arithmetic reference
module tb_best_d_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] n = '0;
  logic [4:0] t = '0;
  logic [10:0] d;
  logic [3:0] u_minus_1;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [10:0] d;
    logic [3:0] u;
    string tag;
  } exp_t;
  exp_t q[$];
  best_d_core dut (.clk(clk), .rst(rst), .n(n), .t(t), .d(d), .u_minus_1(u_minus_1));
  always #5 clk = ~clk;
  function automatic exp_t model(input int nn, input int tt, input string tag);
    exp_t e;
    longint m, r;
    int u;
    m = 2 * nn - (tt - 1);
    if (tt == 0) u = 10;
    else if (m <= 0) u = 1;
    else begin
      r = (m * 45426) / (longint'(tt) * 131072);
      u = 0;
      while ((longint'(1) << (u + 1)) <= r) u++;
      u = u < 1 ? 1 : (u > 10 ? 10 : u);
    end
    e.d = 11'(1 << u);
    e.u = 4'(u - 1);
    e.tag = tag;
    return e;
  endfunction
  task automatic check(input string tag, input logic [10:0] ed, input logic [3:0] eu);
    total++;
    assert (d === ed && u_minus_1 === eu) else begin
      bad++;
      $error("FAIL %s: got d=%0d u_minus_1=%0d, want d=%0d u_minus_1=%0d", tag, d, u_minus_1, ed, eu);
    end
  endtask
  task automatic step(input int nn, input int tt, input int cd = -1, input int cu = -1, input string tag = "rand");
    exp_t e;
    n = 12'(nn);
    t = 5'(tt);
    e = model(nn, tt, tag);
    if (cd >= 0) begin
      e.d = 11'(cd);
      e.u = 4'(cu);
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 2) begin
      e = q.pop_front();
      check(e.tag, e.d, e.u);
    end
  endtask
  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    check(tag, 11'd0, 4'd0);
    rst = 1'b0;
  endtask
  initial begin
    int ns[5] = '{1, 64, 1000, 2048, 4095};
    n = 12'd2048;
    t = 5'd3;
    @(posedge clk);
    do_reset("reset_state");
    for (int i = 1; i <= 13; i++)
      step(2048, i, i == 1 ? 1024 : i == 2 ? 512 : i == 3 ? 256 : i == 10 ? 128 : -1,
           i == 1 ? 9 : i == 2 ? 8 : i == 3 ? 7 : i == 10 ? 6 : -1, $sformatf("sweep_t%0d", i));
    do_reset("reset_mid_sweep");
    for (int i = 14; i <= 27; i++)
      step(2048, i, i == 27 ? 32 : -1, i == 27 ? 4 : -1, $sformatf("sweep_t%0d", i));
    step(0, 0, 1024, 9, "t0_n0");
    step(3000, 0, 1024, 9, "t0_n3000");
    step(5, 20, 2, 0, "m_neg");
    step(0, 1, 2, 0, "m_zero");
    step(4095, 1, 1024, 9, "n_max_cap");
    step(3, 1, 2, 0, "n3_t1");
    step(4095, 31, -1, -1, "n_max_t_max");
    foreach (ns[j])
      for (int i = 0; i < 32; i++) step(ns[j], i, -1, -1, $sformatf("grid_n%0d_t%0d", ns[j], i));
    repeat (300) step(int'($urandom_range(0, 4095)), int'($urandom_range(0, 31)));
    step(0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
